// File: rtl/nanaseg_pkg.sv
// rtl/nanaseg_pkg.sv - shared types, segment patterns and helpers for the score display
// Contents: segment patterns for digits 0-9, SEG_BLANK word, digit-enable bit positions,
//           converter state enum, scan phase enum, digit index type, packed 3-digit BCD struct.
package nanaseg_pkg;

    // Segment bits 0,1,2(dp),3,4,6,9,10 are active-low; bits 7,8,11 are digit enables.
    // Segment mapping: a=0 b=1 c=3 d=6 e=9 f=10 g=4 dp=2.
    localparam logic [11:0] SEG_BLANK = 12'h65F;

    localparam int EN_ONES_BIT  = 7;
    localparam int EN_TENS_BIT  = 8;
    localparam int EN_HUNDS_BIT = 11;

    typedef enum logic [1:0] {IDLE, CONV, DONE} conv_state_t;
    typedef enum logic {BLANK, SHOW} scan_phase_t;

    typedef logic [1:0] digit_idx_t;
    localparam digit_idx_t DIG_ONES  = 2'd0;
    localparam digit_idx_t DIG_TENS  = 2'd1;
    localparam digit_idx_t DIG_HUNDS = 2'd2;

    typedef struct packed {
        logic [3:0] hunds;
        logic [3:0] tens;
        logic [3:0] ones;
    } bcd3_t;

    function automatic logic [11:0] seg_pattern(input logic [3:0] d);
        case (d)
            4'd0:    return 12'h014;
            4'd1:    return 12'h655;
            4'd2:    return 12'h40C;
            4'd3:    return 12'h604;
            4'd4:    return 12'h245;
            4'd5:    return 12'h206;
            4'd6:    return 12'h006;
            4'd7:    return 12'h654;
            4'd8:    return 12'h004;
            4'd9:    return 12'h204;
            default: return SEG_BLANK;
        endcase
    endfunction

    function automatic logic [11:0] digit_enable(input digit_idx_t d);
        case (d)
            DIG_ONES:  return 12'(1) << EN_ONES_BIT;
            DIG_TENS:  return 12'(1) << EN_TENS_BIT;
            DIG_HUNDS: return 12'(1) << EN_HUNDS_BIT;
            default:   return 12'h000;
        endcase
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential double-dabble converter, one bit per clock
// Ports: clk, rst_n (async active-low), start (accept din when idle), din (binary score),
//        busy (conversion in flight), done (1-cycle, BCD valid), ones/tens/hunds (BCD digits).
// Inputs above 999 saturate to 999 at capture.
module bin2bcd_seq
    import nanaseg_pkg::*;
#(
    parameter int SCORE_W = 11
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [SCORE_W-1:0] din,
    output logic               busy,
    output logic               done,
    output logic [3:0]         ones,
    output logic [3:0]         tens,
    output logic [3:0]         hunds
);

    localparam int CW = $clog2(SCORE_W + 1);
    localparam logic [CW-1:0]      CNT_LAST = CW'(SCORE_W - 1);
    localparam logic [SCORE_W-1:0] SAT_MAX  = SCORE_W'(999);

    conv_state_t        state, state_nxt;
    logic [CW-1:0]      cnt;
    logic [SCORE_W-1:0] bin;
    logic [11:0]        bcd;
    logic [3:0]         ones_adj, tens_adj;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CONV;
            CONV:    if (cnt == CNT_LAST) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The hundreds nibble never reaches 5 before the final shift because the
    // input is clamped to 999, so only ones and tens need the add-3 step.
    assign ones_adj = (bcd[3:0] >= 4'd5) ? bcd[3:0] + 4'd3 : bcd[3:0];
    assign tens_adj = (bcd[7:4] >= 4'd5) ? bcd[7:4] + 4'd3 : bcd[7:4];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            bin <= '0;
            bcd <= '0;
        end else if (state == IDLE && start) begin
            cnt <= '0;
            bin <= (din > SAT_MAX) ? SAT_MAX : din;
            bcd <= '0;
        end else if (state == CONV) begin
            cnt <= cnt + 1'b1;
            bin <= {bin[SCORE_W-2:0], 1'b0};
            bcd <= {bcd[10:8], tens_adj, ones_adj, bin[SCORE_W-1]};
        end
    end

    assign busy  = (state != IDLE);
    assign done  = (state == DONE);
    assign ones  = bcd[3:0];
    assign tens  = bcd[7:4];
    assign hunds = bcd[11:8];

endmodule

// File: rtl/score_display_ctrl.sv
// rtl/score_display_ctrl.sv - 3-digit score display: BCD conversion, tear-free update, digit scan
// Ports: CLOCK10M, RESET_N (async active-low), score/score_valid/score_ready (score handshake),
//        seg_output (12-bit panel word), frame_start (pulse at first ones-digit SHOW clock).
// Optional: LEADING_ZERO_BLANK_EN blanks leading zero hundreds/tens digits during SHOW.
module score_display_ctrl
    import nanaseg_pkg::*;
#(
    parameter int SCORE_W      = 11,
    parameter int DWELL_CYCLES = 10000,
    parameter int BLANK_CYCLES = 100
) (
    input  logic               CLOCK10M,
    input  logic               RESET_N,
    input  logic [SCORE_W-1:0] score,
    input  logic               score_valid,
    output logic               score_ready,
    output logic [11:0]        seg_output,
    output logic               frame_start
);

    localparam int DCW = $clog2(DWELL_CYCLES + 1);
    localparam int BCW = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;
    localparam logic [DCW-1:0] DWELL_LAST = DCW'(DWELL_CYCLES - 1);
    localparam logic [BCW-1:0] BLANK_LAST = (BLANK_CYCLES > 0) ? BCW'(BLANK_CYCLES - 1) : '0;

    logic        conv_busy, conv_done;
    bcd3_t       conv_bcd;
    bcd3_t       shadow, shadow_nxt, disp, disp_nxt;
    logic        pending, pending_nxt;

    scan_phase_t    phase, phase_nxt;
    digit_idx_t     digit, digit_nxt;
    logic [DCW-1:0] dwell_cnt, dwell_nxt;
    logic [BCW-1:0] blank_cnt, blank_nxt;
    logic           frame_edge;
    logic [11:0]    seg_nxt;
    logic [3:0]     digit_val;
    logic           fs_nxt;

    bin2bcd_seq #(.SCORE_W(SCORE_W)) u_conv (
        .clk   (CLOCK10M),
        .rst_n (RESET_N),
        .start (score_valid && score_ready),
        .din   (score),
        .busy  (conv_busy),
        .done  (conv_done),
        .ones  (conv_bcd.ones),
        .tens  (conv_bcd.tens),
        .hunds (conv_bcd.hunds)
    );

    assign score_ready = !conv_busy;

    always_comb begin
        phase_nxt = phase;
        digit_nxt = digit;
        dwell_nxt = '0;
        blank_nxt = '0;
        case (phase)
            BLANK: begin
                if (BLANK_CYCLES == 0 || blank_cnt == BLANK_LAST) phase_nxt = SHOW;
                else                                              blank_nxt = blank_cnt + 1'b1;
            end
            SHOW: begin
                if (dwell_cnt == DWELL_LAST) begin
                    digit_nxt = (digit == DIG_HUNDS) ? DIG_ONES : digit_idx_t'(digit + 2'd1);
                    if (BLANK_CYCLES > 0) phase_nxt = BLANK;
                end else begin
                    dwell_nxt = dwell_cnt + 1'b1;
                end
            end
            default: phase_nxt = BLANK;
        endcase
    end

    // Last clock of the hundreds SHOW: the next clock starts a new frame.
    assign frame_edge = (phase == SHOW) && (digit == DIG_HUNDS) && (dwell_cnt == DWELL_LAST);

    // A conversion finishing on the frame edge is forwarded straight into the display.
    always_comb begin
        shadow_nxt  = shadow;
        disp_nxt    = disp;
        pending_nxt = pending;
        if (conv_done) begin
            shadow_nxt  = conv_bcd;
            pending_nxt = 1'b1;
        end
        if (frame_edge && pending_nxt) begin
            disp_nxt    = shadow_nxt;
            pending_nxt = 1'b0;
        end
    end

    // Output word is computed from next-cycle state so the register lines up with the scan.
    always_comb begin
        seg_nxt   = SEG_BLANK;
        digit_val = disp_nxt.ones;
        if (digit_nxt == DIG_TENS)  digit_val = disp_nxt.tens;
        if (digit_nxt == DIG_HUNDS) digit_val = disp_nxt.hunds;
        if (phase_nxt == SHOW) begin
            seg_nxt = seg_pattern(digit_val);
`ifdef LEADING_ZERO_BLANK_EN
            if ((digit_nxt == DIG_HUNDS && disp_nxt.hunds == 4'd0) ||
                (digit_nxt == DIG_TENS && disp_nxt.hunds == 4'd0 && disp_nxt.tens == 4'd0))
                seg_nxt = SEG_BLANK;
`endif
            seg_nxt = seg_nxt | digit_enable(digit_nxt);
        end
        fs_nxt = (phase_nxt == SHOW) && (digit_nxt == DIG_ONES) &&
                 !((phase == SHOW) && (digit == DIG_ONES));
    end

    always_ff @(posedge CLOCK10M or negedge RESET_N) begin
        if (!RESET_N) begin
            phase       <= BLANK;
            digit       <= DIG_ONES;
            dwell_cnt   <= '0;
            blank_cnt   <= '0;
            shadow      <= '0;
            disp        <= '0;
            pending     <= 1'b0;
            seg_output  <= SEG_BLANK;
            frame_start <= 1'b0;
        end else begin
            phase       <= phase_nxt;
            digit       <= digit_nxt;
            dwell_cnt   <= dwell_nxt;
            blank_cnt   <= blank_nxt;
            shadow      <= shadow_nxt;
            disp        <= disp_nxt;
            pending     <= pending_nxt;
            seg_output  <= seg_nxt;
            frame_start <= fs_nxt;
        end
    end

endmodule
